// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an RGB LCD: registered HSYNC/VSYNC/DE, pixel
// coordinates and line/frame strobes, all decoded from one (h_cnt, v_cnt) pair.
module lcd_timing_gen #(
  parameter int H_ACTIVE        = 480,
  parameter int H_FP            = 8,
  parameter int H_SYNC          = 4,
  parameter int H_BP            = 43,
  parameter int V_ACTIVE        = 272,
  parameter int V_FP            = 8,
  parameter int V_SYNC          = 4,
  parameter int V_BP            = 12,
  parameter int SYNC_ACTIVE_LOW = 1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap, v_wrap, hs_on, vs_on, de_on, at_h0, at_v0;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    hs_on  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_on  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    de_on  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    at_h0  = (h_cnt == '0);
    at_v0  = (v_cnt == '0);
  end

  // Outputs capture the decode of the current position before the counters move,
  // so every output refers to the same pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_hsync       <= SYNC_IDLE;
      o_vsync       <= SYNC_IDLE;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_x           <= h_cnt;
      o_y           <= v_cnt;
      o_de          <= de_on;
      o_hsync       <= hs_on ? ~SYNC_IDLE : SYNC_IDLE;
      o_vsync       <= vs_on ? ~SYNC_IDLE : SYNC_IDLE;
      o_line_start  <= at_h0;
      o_frame_start <= at_h0 && at_v0;
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default 480x272 instance plus two small-raster instances
// (active-low and active-high syncs) checked against a linear-pixel-index model.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // default instance
  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  lcd_timing_gen u_def (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de), .o_x(d_x), .o_y(d_y),
    .o_line_start(d_ls), .o_frame_start(d_fs)
  );

  // small raster, active-low syncs
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_LOW(1)
  ) u_small (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de), .o_x(s_x), .o_y(s_y),
    .o_line_start(s_ls), .o_frame_start(s_fs)
  );

  // small raster, active-high syncs
  logic       p_hs, p_vs, p_de, p_ls, p_fs;
  logic [2:0] p_x, p_y;
  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_LOW(0)
  ) u_pos (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hsync(p_hs), .o_vsync(p_vs), .o_de(p_de), .o_x(p_x), .o_y(p_y),
    .o_line_start(p_ls), .o_frame_start(p_fs)
  );

  // Reference model: a pixel index walking the frame; position is index mod/div width.
  localparam int S_HT = 8, S_VT = 6;
  localparam int D_HT = 535, D_VT = 296;
  int sp = 0, dp = 0;
  int mx = 0, my = 0, dmx = 0, dmy = 0;
  bit mde = 0, mhs = 0, mvs = 0, mls = 0, mfs = 0;

  task automatic step(input logic r, input logic e);
    int h, v;
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      sp = 0; dp = 0; mx = 0; my = 0; dmx = 0; dmy = 0;
      mde = 0; mhs = 0; mvs = 0; mls = 0; mfs = 0;
    end else if (e) begin
      h = sp % S_HT;
      v = sp / S_HT;
      mx  = h;
      my  = v;
      mde = (h < 4) && (v < 3);
      mhs = (h >= 5) && (h <= 6);
      mvs = (v == 4);
      mls = (h == 0);
      mfs = (sp == 0);
      sp  = (sp + 1) % (S_HT * S_VT);
      dmx = dp % D_HT;
      dmy = dp / D_HT;
      dp  = (dp + 1) % (D_HT * D_VT);
    end else begin
      mls = 0;
      mfs = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1); step(1, 1); step(1, 1);
    n_checks++; if (d_x !== 10'd0)  begin n_fail++; $display("FAIL reset_d_x got %0d want 0", d_x); end
    n_checks++; if (d_y !== 9'd0)   begin n_fail++; $display("FAIL reset_d_y got %0d want 0", d_y); end
    n_checks++; if (d_de !== 1'b0)  begin n_fail++; $display("FAIL reset_d_de got %b want 0", d_de); end
    n_checks++; if (d_hs !== 1'b1)  begin n_fail++; $display("FAIL reset_d_hsync got %b want 1", d_hs); end
    n_checks++; if (d_vs !== 1'b1)  begin n_fail++; $display("FAIL reset_d_vsync got %b want 1", d_vs); end
    n_checks++; if (d_ls !== 1'b0 || d_fs !== 1'b0)
      begin n_fail++; $display("FAIL reset_d_strobes got %b%b want 00", d_ls, d_fs); end
    n_checks++; if (p_hs !== 1'b0 || p_vs !== 1'b0)
      begin n_fail++; $display("FAIL reset_pos_syncs got %b%b want 00", p_hs, p_vs); end
  endtask

  task automatic test_default_frame();
    localparam int LINES = 112;
    int n_de, n_hs, n_vs, n_fs;
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    for (int i = 0; i < LINES * D_HT; i++) begin
      step(0, 1);
      n_de += int'(d_de);
      n_hs += int'(d_hs == 1'b0);
      n_vs += int'(d_vs == 1'b0);
      n_fs += int'(d_fs);
    end
    n_checks++; if (n_de != LINES * 480) begin n_fail++; $display("FAIL def_de_count got %0d want %0d", n_de, LINES * 480); end
    n_checks++; if (n_hs != LINES * 4)   begin n_fail++; $display("FAIL def_hsync_count got %0d want %0d", n_hs, LINES * 4); end
    n_checks++; if (n_vs != 0)           begin n_fail++; $display("FAIL def_vsync_count got %0d want 0", n_vs); end
    n_checks++; if (n_fs != 1)           begin n_fail++; $display("FAIL def_frame_start got %0d want 1", n_fs); end
    n_checks++; if (int'(d_x) != dmx || int'(d_y) != dmy)
      begin n_fail++; $display("FAIL def_pos got (%0d,%0d) want (%0d,%0d)", d_x, d_y, dmx, dmy); end
  endtask

  task automatic test_line_sequence();
    step(1, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1);
      n_checks++; if (int'(s_x) != i % 8) begin n_fail++; $display("FAIL line_x i=%0d got %0d want %0d", i, s_x, i % 8); end
      n_checks++; if (s_hs !== !((i % 8) == 5 || (i % 8) == 6))
        begin n_fail++; $display("FAIL line_hsync x=%0d got %b", i % 8, s_hs); end
      n_checks++; if (s_de !== ((i % 8) < 4)) begin n_fail++; $display("FAIL line_de x=%0d got %b", i % 8, s_de); end
      if (i == 8) begin
        n_checks++; if (s_y !== 3'd1 || s_ls !== 1'b1)
          begin n_fail++; $display("FAIL line_wrap got y=%0d ls=%b want y=1 ls=1", s_y, s_ls); end
      end
    end
  endtask

  task automatic test_frame_wrap();
    int fs_a, fs_b, n_vs, prev_y;
    fs_a = -1; fs_b = -1; n_vs = 0; prev_y = 0;
    step(1, 0);
    for (int i = 0; i < 97; i++) begin
      step(0, 1);
      if (s_fs === 1'b1) begin
        if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i;
        if (i > 0) begin
          n_checks++; if (prev_y != 5 || s_y !== 3'd0 || s_x !== 3'd0)
            begin n_fail++; $display("FAIL frame_wrap got y %0d->%0d x=%0d want 5->0 x=0", prev_y, s_y, s_x); end
        end
      end
      if (i < 48) begin
        n_vs += int'(s_vs == 1'b0);
        n_checks++; if (s_vs !== (s_y != 3'd4)) begin n_fail++; $display("FAIL frame_vsync y=%0d got %b", s_y, s_vs); end
      end
      prev_y = int'(s_y);
    end
    n_checks++; if (n_vs != 8) begin n_fail++; $display("FAIL frame_vsync_count got %0d want 8", n_vs); end
    n_checks++; if (fs_a != 0 || fs_b - fs_a != 48)
      begin n_fail++; $display("FAIL frame_period got first=%0d second=%0d want 0,48", fs_a, fs_b); end
  endtask

  task automatic test_enable_toggle();
    int fs_a, fs_b;
    bit prev_ls, prev_fs;
    logic [2:0] hx, hy;
    logic hde;
    fs_a = -1; fs_b = -1; prev_ls = 0; prev_fs = 0;
    step(1, 0);
    for (int i = 0; i < 200; i++) begin
      hx = s_x; hy = s_y; hde = s_de;
      step(0, (i % 2) == 0);
      if (s_fs === 1'b1) begin if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i; end
      if (i % 2 == 1) begin
        n_checks++; if (s_x !== hx || s_y !== hy || s_de !== hde || s_ls !== 1'b0 || s_fs !== 1'b0)
          begin n_fail++; $display("FAIL toggle_hold i=%0d got (%0d,%0d,%b,%b%b)", i, s_x, s_y, s_de, s_ls, s_fs); end
      end
      n_checks++; if ((prev_ls && s_ls) || (prev_fs && s_fs))
        begin n_fail++; $display("FAIL toggle_strobe_width i=%0d ls=%b fs=%b", i, s_ls, s_fs); end
      prev_ls = s_ls; prev_fs = s_fs;
    end
    n_checks++; if (fs_b - fs_a != 96) begin n_fail++; $display("FAIL toggle_period got %0d want 96", fs_b - fs_a); end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 0;
    step(1, 0);
    for (int i = 0; i < 60 && !found; i++) begin
      step(0, 1);
      if (s_x == 3'd3 && s_y == 3'd2) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midrst_reach got (%0d,%0d) want (3,2)", s_x, s_y); end
    step(1, 1);
    n_checks++; if (s_x !== 3'd0 || s_y !== 3'd0 || s_de !== 1'b0 || s_hs !== 1'b1 || s_vs !== 1'b1 || s_ls !== 1'b0 || s_fs !== 1'b0)
      begin n_fail++; $display("FAIL midrst_values got (%0d,%0d) de=%b hs=%b vs=%b ls=%b fs=%b", s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs); end
    step(0, 1);
    n_checks++; if (s_x !== 3'd0 || s_y !== 3'd0 || s_de !== 1'b1 || s_fs !== 1'b1 || s_ls !== 1'b1)
      begin n_fail++; $display("FAIL midrst_first got (%0d,%0d) de=%b ls=%b fs=%b want (0,0) 1 1 1", s_x, s_y, s_de, s_ls, s_fs); end
  endtask

  task automatic test_polarity();
    step(1, 0);
    n_checks++; if (p_hs !== 1'b0 || p_vs !== 1'b0) begin n_fail++; $display("FAIL pol_reset got %b%b want 00", p_hs, p_vs); end
    for (int i = 0; i < 9; i++) begin
      step(0, 1);
      n_checks++; if (p_hs !== ((i % 8) == 5 || (i % 8) == 6))
        begin n_fail++; $display("FAIL pol_hsync x=%0d got %b", i % 8, p_hs); end
      n_checks++; if (p_vs !== 1'b0) begin n_fail++; $display("FAIL pol_vsync got %b want 0", p_vs); end
    end
  endtask

  task automatic test_random();
    logic r, e;
    step(1, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(63) == 0);
      e = $urandom_range(3) != 0;
      step(r, e);
      n_checks++; if (int'(s_x) != mx || int'(s_y) != my || s_de !== mde)
        begin n_fail++; $display("FAIL rand_pos i=%0d got (%0d,%0d,%b) want (%0d,%0d,%b)", i, s_x, s_y, s_de, mx, my, mde); end
      n_checks++; if (s_hs !== !mhs || s_vs !== !mvs || p_hs !== mhs || p_vs !== mvs)
        begin n_fail++; $display("FAIL rand_sync i=%0d got s=%b%b p=%b%b want on=%b%b", i, s_hs, s_vs, p_hs, p_vs, mhs, mvs); end
      n_checks++; if (s_ls !== mls || s_fs !== mfs)
        begin n_fail++; $display("FAIL rand_strobe i=%0d got %b%b want %b%b", i, s_ls, s_fs, mls, mfs); end
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_line_sequence();
    test_frame_wrap();
    test_enable_toggle();
    test_mid_reset();
    test_polarity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
